data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Command sequencer that owns the write port and the select-read port of the 4-entry x 16-bit data memory.
- Accepts single-word write/read and whole-memory fill/dump commands from the core over a valid/ready handshake, then drives w_add/w_flag/w_data and rsel_addr.
- Returns read data over a valid/ready response channel.
- Sits between the control unit/debug path and the data memory; the r_add1/r_add2 ports stay with the datapath.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 2, memory address width
- DEPTH, 4, number of entries (2**ADDR_W); last address is DEPTH-1

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 DUMP
- cmd_addr  in  ADDR_W  target address (WRITE/READ only)
- cmd_data  in  DATA_W  write/fill data (WRITE/FILL only)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  read word
- rsp_addr  out  ADDR_W  address of rsp_data
- rsp_last  out  1  final response of a command (always 1 for READ; 1 only on entry DEPTH-1 for DUMP)
- busy  out  1  command in progress (state != IDLE)
- mem_w_add  out  ADDR_W  to memory w_add
- mem_w_flag  out  1  to memory w_flag
- mem_w_data  out  DATA_W  to memory w_data
- mem_rsel_addr  out  ADDR_W  to memory rsel_addr
- mem_rsel_data  in  DATA_W  from memory rsel_data (combinational read)

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; mem_w_flag=0, mem_w_add=0, mem_w_data=0, mem_rsel_addr=0.
  - rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0; busy=0; index counter=0.
  - Reset mid-command aborts it: no further writes are issued and a pending response is dropped. Memory contents are not cleared by this block.
- cmd_ready = (state==IDLE) && reset==1. A command is accepted on a posedge with cmd_valid && cmd_ready; cmd_op/addr/data are latched then.
- All mem_* outputs are registered; they change only at posedge. This keeps mem_w_flag/w_add/w_data stable across the memory's negedge write.
- States: IDLE, WR, FILL, RD, RSP.
- WRITE (accepted at edge N):
  - In cycle N+1, state WR with mem_w_flag=1, mem_w_add=cmd_addr, mem_w_data=cmd_data; the memory writes on the negedge inside that cycle.
  - Edge N+2: mem_w_flag=0, IDLE. cmd_ready is high again in cycle N+2.
- FILL:
  - States FILL for DEPTH cycles with mem_w_flag=1, mem_w_data=cmd_data and mem_w_add=0,1,2,3 in consecutive cycles.
  - The index wraps to 0 after DEPTH-1, then IDLE with mem_w_flag=0.
  - Total occupancy is DEPTH cycles; no response is produced.
- READ:
  - In cycle N+1, state RD with mem_rsel_addr=cmd_addr.
  - At edge N+2, rsp_data<=mem_rsel_data, rsp_addr<=cmd_addr, rsp_last<=1, rsp_valid<=1; state RSP.
- RSP:
  - rsp_valid, rsp_data, rsp_addr and rsp_last are held stable until rsp_ready==1 at a posedge.
  - On that edge rsp_valid<=0. For READ, or DUMP when index==DEPTH-1, go to IDLE. Otherwise increment the index and go to RD.
- DUMP:
  - The index starts at 0 and runs RD→RSP per entry, producing DEPTH responses in address order. rsp_last=1 only on the response for address DEPTH-1.
  - With rsp_ready held high, there is one response every 2 cycles; the first rsp_valid appears 2 cycles after acceptance.
- rsp_valid is never asserted while mem_w_flag=1. Write and read phases of different commands never overlap.
- A second cmd_valid during busy is ignored; cmd_ready=0, so the requester holds cmd_valid and cmd_op/addr/data stable until acceptance.
- The index counter is ADDR_W+1 bits wide so DEPTH-1 is detectable without relying on overflow. Only the low ADDR_W bits drive the mem_* address outputs.
- Read-after-write: a READ accepted the cycle WR finishes returns the new value, because the write completed on the negedge before the RD capture edge.

Test Plan:
- Reset held low 3 cycles with cmd_valid=1 → cmd_ready=0, mem_w_flag=0, rsp_valid=0 throughout. Release → cmd_ready=1 next cycle.
- WRITE addr=2 data=16'hBEEF, then READ addr=2 → exactly one cycle of mem_w_flag=1 with w_add=2. rsp_valid 2 cycles after READ acceptance with rsp_data=16'hBEEF, rsp_addr=2, rsp_last=1.
- FILL data=16'h1234, then DUMP with rsp_ready=1 → mem_w_add sequence 0,1,2,3 on 4 consecutive cycles. Four responses of 16'h1234 at addr 0..3; rsp_last only on addr 3; busy drops after the last handshake.
- DUMP with rsp_ready low for 5 cycles on the second response → rsp_valid/rsp_data/rsp_addr=1 held stable all 5 cycles; no address skipped; total 4 responses.
- Reset asserted in the second cycle of FILL → mem_w_flag=0 at the next posedge; entries 2 and 3 are not written (pre-load 16'h00AA and verify via READ after reset).
- cmd_valid held high with alternating ops back-to-back → each command accepted only in IDLE; no command lost or duplicated (scoreboard against a 4-entry model).

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Command/response channel and memory-side bus of the data memory sequencer.
// The master modport is the core plus memory side; the slave modport is the controller.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_last;

  logic              busy;

  logic [ADDR_W-1:0] mem_w_add;
  logic              mem_w_flag;
  logic [DATA_W-1:0] mem_w_data;
  logic [ADDR_W-1:0] mem_rsel_addr;
  logic [DATA_W-1:0] mem_rsel_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_rsel_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, busy,
           mem_w_add, mem_w_flag, mem_w_data, mem_rsel_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_rsel_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, busy,
           mem_w_add, mem_w_flag, mem_w_data, mem_rsel_addr
  );

endinterface

// File: rtl/data_mem_ctrl.sv
// Sequencer owning the write port and select-read port of the 4 x 16 data memory.
// Executes WRITE/READ/FILL/DUMP commands and returns read words on a response channel.
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  localparam int               IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, FILL, RD, RSP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dump_q, dump_d;
  logic              w_flag_q, w_flag_d;
  logic [ADDR_W-1:0] w_add_q, w_add_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [ADDR_W-1:0] rsel_q, rsel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;

  logic              accept;
  logic              at_last;
  logic [IDX_W-1:0]  idx_next;

  assign bus.cmd_ready = (state_q == IDLE) && reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign at_last       = (idx_q == LAST_IDX);
  assign idx_next      = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_d      = dump_q;
    w_flag_d    = w_flag_q;
    w_add_d     = w_add_q;
    w_data_d    = w_data_q;
    rsel_d      = rsel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_WRITE: begin
              state_d  = WR;
              w_flag_d = 1'b1;
              w_add_d  = bus.cmd_addr;
              w_data_d = bus.cmd_data;
            end
            OP_READ: begin
              state_d = RD;
              dump_d  = 1'b0;
              rsel_d  = bus.cmd_addr;
            end
            OP_FILL: begin
              state_d  = FILL;
              idx_d    = '0;
              w_flag_d = 1'b1;
              w_add_d  = '0;
              w_data_d = bus.cmd_data;
            end
            default: begin
              state_d = RD;
              dump_d  = 1'b1;
              idx_d   = '0;
              rsel_d  = '0;
            end
          endcase
        end
      end

      WR: begin
        w_flag_d = 1'b0;
        state_d  = IDLE;
      end

      FILL: begin
        if (at_last) begin
          w_flag_d = 1'b0;
          idx_d    = '0;
          state_d  = IDLE;
        end else begin
          idx_d   = idx_next;
          w_add_d = idx_next[ADDR_W-1:0];
        end
      end

      // The memory read is combinational, so the word is captured on the edge ending RD.
      RD: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.mem_rsel_data;
        rsp_addr_d  = rsel_q;
        rsp_last_d  = !dump_q || at_last;
        state_d     = RSP;
      end

      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!dump_q || at_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_next;
            rsel_d  = idx_next[ADDR_W-1:0];
            state_d = RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dump_q      <= 1'b0;
      w_flag_q    <= 1'b0;
      w_add_q     <= '0;
      w_data_q    <= '0;
      rsel_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_q      <= dump_d;
      w_flag_q    <= w_flag_d;
      w_add_q     <= w_add_d;
      w_data_q    <= w_data_d;
      rsel_q      <= rsel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_w_flag    = w_flag_q;
  assign bus.mem_w_add     = w_add_q;
  assign bus.mem_w_data    = w_data_q;
  assign bus.mem_rsel_addr = rsel_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_addr      = rsp_addr_q;
  assign bus.rsp_last      = rsp_last_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a command-level model predicts writes and responses,
// and directed tests pin the model with hand-computed literal expectations.
module tb_data_mem_ctrl;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  logic clk = 1'b0;
  logic reset;

  data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(2)) bus ();

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(2), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory stand-in: negedge write, combinational select read.
  logic [15:0] mem [4] = '{default: 16'h0000};
  always @(negedge clk) if (bus.mem_w_flag) mem[bus.mem_w_add] <= bus.mem_w_data;
  assign bus.mem_rsel_data = mem[bus.mem_rsel_addr];

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int acc_cycle = 0;
  int acc_count = 0;

  always @(posedge clk) cycle <= cycle + 1;

  logic [15:0] log_rsp_data [$];
  logic [1:0]  log_rsp_addr [$];
  logic        log_rsp_last [$];
  int          log_rsp_cyc  [$];
  logic [1:0]  log_w_addr   [$];
  int          log_w_cyc    [$];
  int          valid_cnt    [4];

  typedef struct packed {logic [1:0] addr; logic [15:0] data;} wr_t;
  wr_t         wq [$];
  logic [1:0]  rq_addr [$];
  logic        rq_last [$];
  logic [15:0] m_mem [4] = '{default: 16'h0000};
  bit          m_busy = 0;
  bit          m_gap = 0;
  bit          m_in_reset = 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearLogs();
    log_rsp_data.delete(); log_rsp_addr.delete(); log_rsp_last.delete(); log_rsp_cyc.delete();
    log_w_addr.delete(); log_w_cyc.delete();
    for (int i = 0; i < 4; i++) valid_cnt[i] = 0;
  endtask

  // Presents a command and holds it until accepted; leaves cmd_valid high for back-to-back use.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] data);
    bit got = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc_cycle = cycle;
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle();
    bit done = 0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Compare process: checks outputs against the model, then advances the model for the next edge.
  initial begin : compare
    bit          w_seen, exp_rv, accept, hold_pending;
    logic [15:0] hold_data;
    logic [1:0]  hold_addr;
    logic        hold_last;
    hold_pending = 0;
    hold_data = '0; hold_addr = '0; hold_last = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      w_seen = 0;
      if (m_in_reset) begin
        checkOutput("rst_cmd_ready", bus.cmd_ready, reset);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_rsp_data", bus.rsp_data, 0);
        checkOutput("rst_w_add", bus.mem_w_add, 0);
        checkOutput("rst_rsel", bus.mem_rsel_addr, 0);
      end else begin
        checkOutput("busy", bus.busy, m_busy);
        checkOutput("cmd_ready", bus.cmd_ready, !m_busy && reset);
      end
      checkOutput("w_flag", bus.mem_w_flag, wq.size() != 0);
      if (bus.mem_w_flag && wq.size() != 0) begin
        checkOutput("w_add", bus.mem_w_add, wq[0].addr);
        checkOutput("w_data", bus.mem_w_data, wq[0].data);
        m_mem[wq[0].addr] = wq[0].data;
        log_w_addr.push_back(wq[0].addr);
        log_w_cyc.push_back(cycle);
        void'(wq.pop_front());
        w_seen = 1;
      end
      exp_rv = (rq_addr.size() != 0) && !m_gap;
      checkOutput("rsp_valid", bus.rsp_valid, exp_rv);
      if (bus.rsp_valid && exp_rv) begin
        checkOutput("rsp_addr", bus.rsp_addr, rq_addr[0]);
        checkOutput("rsp_last", bus.rsp_last, rq_last[0]);
        checkOutput("rsp_data", bus.rsp_data, m_mem[rq_addr[0]]);
        if (hold_pending) begin
          checkOutput("hold_data", bus.rsp_data, hold_data);
          checkOutput("hold_addr", bus.rsp_addr, hold_addr);
          checkOutput("hold_last", bus.rsp_last, hold_last);
        end
        valid_cnt[bus.rsp_addr]++;
      end

      hold_pending = 0;
      if (!reset) begin
        wq.delete(); rq_addr.delete(); rq_last.delete();
        m_busy = 0; m_gap = 0; m_in_reset = 1;
      end else begin
        accept = bus.cmd_valid && !m_busy;
        m_in_reset = 0;
        if (w_seen && wq.size() == 0) m_busy = 0;
        if (exp_rv && bus.rsp_ready) begin
          log_rsp_data.push_back(bus.rsp_data);
          log_rsp_addr.push_back(bus.rsp_addr);
          log_rsp_last.push_back(bus.rsp_last);
          log_rsp_cyc.push_back(cycle);
          void'(rq_addr.pop_front());
          void'(rq_last.pop_front());
          if (rq_addr.size() == 0) m_busy = 0;
          else m_gap = 1;
        end else if (exp_rv) begin
          hold_pending = 1;
          hold_data = bus.rsp_data; hold_addr = bus.rsp_addr; hold_last = bus.rsp_last;
        end else if (m_gap) begin
          m_gap = 0;
        end
        if (accept) begin
          m_busy = 1;
          acc_count++;
          case (bus.cmd_op)
            OP_WRITE: wq.push_back('{addr: bus.cmd_addr, data: bus.cmd_data});
            OP_READ: begin
              rq_addr.push_back(bus.cmd_addr); rq_last.push_back(1'b1); m_gap = 1;
            end
            OP_FILL: for (int i = 0; i < 4; i++) wq.push_back('{addr: 2'(i), data: bus.cmd_data});
            default: begin
              for (int i = 0; i < 4; i++) begin
                rq_addr.push_back(2'(i)); rq_last.push_back(i == 3);
              end
              m_gap = 1;
            end
          endcase
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int held;
    logic [15:0] exp6 [7];
    reset = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_WRITE;
    bus.cmd_addr = 2'd1;
    bus.cmd_data = 16'h5555;
    bus.rsp_ready = 1'b1;

    // Reset held three cycles with a command pending.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("t1_cmd_ready", bus.cmd_ready, 0);
      checkOutput("t1_w_flag", bus.mem_w_flag, 0);
      checkOutput("t1_rsp_valid", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_ready_after_release", bus.cmd_ready, 1);
    @(posedge clk); #1;

    // WRITE then READ of the same address.
    clearLogs();
    applyStimulus(OP_WRITE, 2'd2, 16'hBEEF);
    held = acc_cycle;
    waitIdle();
    checkOutput("t2_write_count", log_w_addr.size(), 1);
    checkOutput("t2_write_addr", log_w_addr[0], 2);
    checkOutput("t2_write_cycle", log_w_cyc[0], held + 1);
    applyStimulus(OP_READ, 2'd2, 16'h0000);
    held = acc_cycle;
    waitIdle();
    checkOutput("t2_rsp_count", log_rsp_data.size(), 1);
    checkOutput("t2_rsp_data", log_rsp_data[0], 16'hBEEF);
    checkOutput("t2_rsp_addr", log_rsp_addr[0], 2);
    checkOutput("t2_rsp_last", log_rsp_last[0], 1);
    checkOutput("t2_rsp_cycle", log_rsp_cyc[0], held + 2);

    // FILL then DUMP with the consumer always ready.
    clearLogs();
    applyStimulus(OP_FILL, 2'd0, 16'h1234);
    held = acc_cycle;
    waitIdle();
    checkOutput("t3_write_count", log_w_addr.size(), 4);
    for (int k = 0; k < 4 && k < log_w_addr.size(); k++) begin
      checkOutput("t3_write_addr", log_w_addr[k], k);
      checkOutput("t3_write_cycle", log_w_cyc[k], held + 1 + k);
    end
    applyStimulus(OP_DUMP, 2'd0, 16'h0000);
    held = acc_cycle;
    waitIdle();
    checkOutput("t3_rsp_count", log_rsp_data.size(), 4);
    for (int k = 0; k < 4 && k < log_rsp_data.size(); k++) begin
      checkOutput("t3_rsp_data", log_rsp_data[k], 16'h1234);
      checkOutput("t3_rsp_addr", log_rsp_addr[k], k);
      checkOutput("t3_rsp_last", log_rsp_last[k], k == 3);
      checkOutput("t3_rsp_cycle", log_rsp_cyc[k], held + 2 + 2 * k);
    end

    // DUMP with the second response stalled for five cycles.
    clearLogs();
    bus.rsp_ready = 1'b0;
    applyStimulus(OP_DUMP, 2'd0, 16'h0000);
    bus.cmd_valid = 1'b0;
    held = 0;
    for (int i = 0; i < 100 && log_rsp_addr.size() < 4; i++) begin
      if (bus.rsp_valid) begin
        if (log_rsp_addr.size() == 1 && held < 5) begin
          held++;
          bus.rsp_ready = 1'b0;
        end else begin
          bus.rsp_ready = 1'b1;
        end
      end else begin
        bus.rsp_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    waitIdle();
    checkOutput("t4_rsp_count", log_rsp_addr.size(), 4);
    for (int k = 0; k < 4 && k < log_rsp_addr.size(); k++)
      checkOutput("t4_rsp_addr", log_rsp_addr[k], k);
    checkOutput("t4_stall_cycles", valid_cnt[1], 6);
    checkOutput("t4_rsp3_cycles", valid_cnt[3], 1);

    // Reset in the second cycle of a FILL aborts the remaining writes.
    applyStimulus(OP_FILL, 2'd0, 16'h00AA);
    waitIdle();
    clearLogs();
    applyStimulus(OP_FILL, 2'd0, 16'h1234);
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_w_flag_after_rst", bus.mem_w_flag, 0);
    checkOutput("t5_busy_after_rst", bus.busy, 0);
    reset = 1'b1;
    checkOutput("t5_write_count", log_w_addr.size(), 2);
    clearLogs();
    for (int a = 0; a < 4; a++) begin
      applyStimulus(OP_READ, 2'(a), 16'h0000);
      waitIdle();
    end
    checkOutput("t5_rsp_count", log_rsp_data.size(), 4);
    if (log_rsp_data.size() == 4) begin
      checkOutput("t5_entry0", log_rsp_data[0], 16'h1234);
      checkOutput("t5_entry1", log_rsp_data[1], 16'h1234);
      checkOutput("t5_entry2", log_rsp_data[2], 16'h00AA);
      checkOutput("t5_entry3", log_rsp_data[3], 16'h00AA);
    end

    // Back-to-back commands with cmd_valid held high throughout.
    clearLogs();
    held = acc_count;
    applyStimulus(OP_WRITE, 2'd0, 16'h1111);
    applyStimulus(OP_READ,  2'd0, 16'h0000);
    applyStimulus(OP_WRITE, 2'd3, 16'h3333);
    applyStimulus(OP_READ,  2'd3, 16'h0000);
    applyStimulus(OP_FILL,  2'd0, 16'h5A5A);
    applyStimulus(OP_DUMP,  2'd0, 16'h0000);
    applyStimulus(OP_WRITE, 2'd1, 16'h0001);
    applyStimulus(OP_READ,  2'd1, 16'h0000);
    waitIdle();
    checkOutput("t6_accepts", acc_count - held, 8);
    exp6 = '{16'h1111, 16'h3333, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h0001};
    checkOutput("t6_rsp_count", log_rsp_data.size(), 7);
    for (int k = 0; k < 7 && k < log_rsp_data.size(); k++)
      checkOutput("t6_rsp_data", log_rsp_data[k], exp6[k]);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
